multiplier_radix_taint_track: RTL and testbench
===============================================

MULTIPLIER_RADIX_TAINT_TRACK -- requirements
Module: multiplier_radix_taint_track

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter WIDTH, default 64, giving the operand width in bits.
REQ-002 The block SHALL have parameter STEP, default 2, giving multiplier bits retired per cycle; legal values are 1, 2 and 4, and STEP SHALL divide WIDTH.
REQ-003 The block SHALL define the derived constant N = WIDTH/STEP as the number of RUN cycles.

Ports (name, direction, width, meaning):
REQ-004 The block SHALL have a port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-005 The block SHALL have a port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have ports start and start_t, input, 1 bit each: request a multiply, and its taint.
REQ-007 The block SHALL have ports signed_mode and signed_mode_t, input, 1 bit each: 1 selects two's-complement operands; plus its taint.
REQ-008 The block SHALL have ports multiplier, multiplier_t, multiplicand and multiplicand_t, input, WIDTH bits each: the operands and their bitwise taint.
REQ-009 The block SHALL have ports product_ack and product_ack_t, input, 1 bit each: the consumer accepts the result; plus its taint.
REQ-010 The block SHALL have ports busy and busy_t, output, 1 bit each: high in RUN; plus its taint.
REQ-011 The block SHALL have ports product and product_t, output, 2*WIDTH bits each: the result and its bitwise taint.
REQ-012 The block SHALL have ports productDone and productDone_t, output, 1 bit each: result valid; plus its taint.

Function
REQ-013 The FSM SHALL have exactly three states, IDLE, RUN and DONE, and SHALL enter IDLE on reset.
REQ-014 In IDLE with start=1, the block SHALL capture multiplier, multiplicand, signed_mode and all their taints; go to RUN; clear the step counter and the running sum.
REQ-015 start SHALL be ignored in RUN and DONE, with no capture and no state change.
REQ-016 In RUN, each cycle SHALL retire STEP multiplier bits using shift-add, and the counter SHALL increment.
REQ-017 RUN SHALL go to DONE after exactly N cycles, independent of operand values (constant time, no early exit on zero operands).
REQ-018 productDone SHALL rise N cycles after the start edge and SHALL stay high in DONE until product_ack=1, which returns the FSM to IDLE on that edge.
REQ-019 product_ack outside DONE SHALL be ignored.
REQ-020 product SHALL be the exact 2*WIDTH-bit product: unsigned when signed_mode=0, two's complement when signed_mode=1.
REQ-021 product SHALL update only on the RUN->DONE edge and SHALL hold the last result through IDLE and the next RUN.
REQ-022 busy SHALL be 1 only in RUN.
REQ-023 Taint, unsigned mode: product_t[k] SHALL be 1 iff some tainted bit of either captured operand has index <= k.
REQ-024 Taint, signed mode: product_t SHALL be all ones if any operand bit is tainted; signed_mode_t=1 SHALL likewise force product_t to all ones.
REQ-025 product_t SHALL update on the same edge as product.
REQ-026 The control-taint register ctl_t SHALL load captured start_t on the IDLE->RUN edge and SHALL OR in product_ack_t on the DONE->IDLE edge.
REQ-027 productDone_t and busy_t SHALL both equal ctl_t.
REQ-028 ctl_t SHALL clear only on an untainted start accepted in IDLE or on reset.

Reset
REQ-029 rst=0 SHALL act immediately at any time, including mid-RUN.
REQ-030 While rst=0, the FSM SHALL be IDLE, and product, product_t, productDone, productDone_t, busy, busy_t, counter, running sum, captured operands and ctl_t SHALL all be 0.
REQ-031 An operation aborted by reset SHALL produce no result.
REQ-032 The first start SHALL be accepted on the first rising edge with rst=1.

Verification (WIDTH=8, STEP=2, N=4)
REQ-033 The bench SHALL apply unsigned 13*11 and check product=16'h008F, productDone high exactly 4 cycles after the start edge, and busy high for 4 cycles.
REQ-034 The bench SHALL apply 8'hFD*8'h05 with signed_mode=1 and check product=16'hFFF1; with signed_mode=0, product=16'h04F1.
REQ-035 The bench SHALL apply unsigned 255*255 and check product=16'hFE01; with signed_mode=1 (-1*-1), product=16'h0001.
REQ-036 The bench SHALL apply multiplier_t=8'h10, other taints 0, and check unsigned product_t=16'hFFF0 and signed product_t=16'hFFFF.
REQ-037 The bench SHALL pulse start in RUN and check it is ignored; it SHALL then assert rst=0 at RUN cycle 2 and check all outputs 0, state IDLE, and a following start completes correctly.
REQ-038 The bench SHALL apply start_t=1 and check busy_t and productDone_t are 1, stay 1 through ack and IDLE, and clear after an untainted start.

Source files
------------

// File: rtl/multiplier_radix_taint_track.sv
// Constant-time radix-2^STEP shift-add multiplier with bitwise taint tracking.
// Signed mode gives the top multiplier bit negative weight on the last step.
module multiplier_radix_taint_track #(
    parameter int WIDTH = 64,
    parameter int STEP  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               start_t,
    input  logic               signed_mode,
    input  logic               signed_mode_t,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic [WIDTH-1:0]   multiplier_t,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplicand_t,
    input  logic               product_ack,
    input  logic               product_ack_t,
    output logic               busy,
    output logic               busy_t,
    output logic [2*WIDTH-1:0] product,
    output logic [2*WIDTH-1:0] product_t,
    output logic               productDone,
    output logic               productDone_t
);

    localparam int N  = WIDTH / STEP;
    localparam int CW = $clog2(N + 1);
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [PW-1:0]   mcd_q, mcd_d;
    logic [WIDTH-1:0] mlr_q, mlr_d;
    logic            sgn_q, sgn_d;
    logic            sgn_t_q, sgn_t_d;
    logic [WIDTH-1:0] opt_q, opt_d;
    logic [PW-1:0]   prod_q, prod_d;
    logic [PW-1:0]   prodt_q, prodt_d;
    logic            ctl_t_q, ctl_t_d;

    logic            last;
    logic [PW-1:0]   sum;
    logic [PW-1:0]   tmask;
    logic [PW-1:0]   opt_ext;
    logic            run_t;

    assign last = (cnt_q == CW'(N - 1));

    always_comb begin
        sum = acc_q;
        for (int j = 0; j < STEP; j++) begin
            if (mlr_q[j]) begin
                if (sgn_q && last && (j == STEP - 1))
                    sum = sum - (mcd_q << j);
                else
                    sum = sum + (mcd_q << j);
            end
        end
    end

    // Taint reaches every product bit at or above the lowest tainted operand bit.
    always_comb begin
        opt_ext = {{WIDTH{1'b0}}, opt_q};
        run_t   = 1'b0;
        tmask   = '0;
        for (int k = 0; k < PW; k++) begin
            run_t    = run_t | opt_ext[k];
            tmask[k] = run_t;
        end
        if ((sgn_q && (|opt_q)) || sgn_t_q)
            tmask = '1;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mcd_d   = mcd_q;
        mlr_d   = mlr_q;
        sgn_d   = sgn_q;
        sgn_t_d = sgn_t_q;
        opt_d   = opt_q;
        prod_d  = prod_q;
        prodt_d = prodt_q;
        ctl_t_d = ctl_t_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    acc_d   = '0;
                    mcd_d   = signed_mode
                            ? {{WIDTH{multiplicand[WIDTH-1]}}, multiplicand}
                            : {{WIDTH{1'b0}}, multiplicand};
                    mlr_d   = multiplier;
                    sgn_d   = signed_mode;
                    sgn_t_d = signed_mode_t;
                    opt_d   = multiplier_t | multiplicand_t;
                    ctl_t_d = start_t;
                end
            end
            RUN: begin
                acc_d = sum;
                mcd_d = mcd_q << STEP;
                mlr_d = mlr_q >> STEP;
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    state_d = DONE;
                    prod_d  = sum;
                    prodt_d = tmask;
                end
            end
            DONE: begin
                if (product_ack) begin
                    state_d = IDLE;
                    ctl_t_d = ctl_t_q | product_ack_t;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mcd_q   <= '0;
            mlr_q   <= '0;
            sgn_q   <= 1'b0;
            sgn_t_q <= 1'b0;
            opt_q   <= '0;
            prod_q  <= '0;
            prodt_q <= '0;
            ctl_t_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mcd_q   <= mcd_d;
            mlr_q   <= mlr_d;
            sgn_q   <= sgn_d;
            sgn_t_q <= sgn_t_d;
            opt_q   <= opt_d;
            prod_q  <= prod_d;
            prodt_q <= prodt_d;
            ctl_t_q <= ctl_t_d;
        end
    end

    assign busy          = (state_q == RUN);
    assign productDone   = (state_q == DONE);
    assign busy_t        = ctl_t_q;
    assign productDone_t = ctl_t_q;
    assign product       = prod_q;
    assign product_t     = prodt_q;

endmodule

// File: tb/tb_multiplier_radix_taint_track.sv
// Directed and random checks of the taint-tracking multiplier (WIDTH=8, STEP=2).
// Expected results come from plain integer arithmetic and taint rules.
module tb_multiplier_radix_taint_track;

    localparam int W = 8;
    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, start_t, signed_mode, signed_mode_t;
    logic [W-1:0]  multiplier, multiplier_t, multiplicand, multiplicand_t;
    logic          product_ack, product_ack_t;
    logic          busy, busy_t, productDone, productDone_t;
    logic [2*W-1:0] product, product_t;

    int total = 0;
    int bad   = 0;
    logic [15:0] prev_p;
    logic [15:0] prev_t;
    logic        ctl_exp;

    multiplier_radix_taint_track #(.WIDTH(W), .STEP(2)) dut (
        .clk(clk), .rst(rst),
        .start(start), .start_t(start_t),
        .signed_mode(signed_mode), .signed_mode_t(signed_mode_t),
        .multiplier(multiplier), .multiplier_t(multiplier_t),
        .multiplicand(multiplicand), .multiplicand_t(multiplicand_t),
        .product_ack(product_ack), .product_ack_t(product_ack_t),
        .busy(busy), .busy_t(busy_t),
        .product(product), .product_t(product_t),
        .productDone(productDone), .productDone_t(productDone_t)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_prod(input logic [7:0] a,
                                             input logic [7:0] b,
                                             input logic sm);
        int sa, sb;
        sa = sm ? int'($signed(a)) : int'(a);
        sb = sm ? int'($signed(b)) : int'(b);
        return 16'(sa * sb);
    endfunction

    function automatic logic [15:0] ref_taint(input logic [7:0] at,
                                              input logic [7:0] bt,
                                              input logic sm,
                                              input logic smt);
        logic [7:0] u;
        u = at | bt;
        if (smt || (sm && (u != 0))) return 16'hFFFF;
        for (int i = 0; i < 8; i++)
            if (u[i]) return 16'hFFFF << i;
        return 16'h0000;
    endfunction

    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic sm, input logic smt, input logic st,
                          input logic [7:0] at, input logic [7:0] bt,
                          input bit poke, input logic ackt);
        logic [15:0] ep, et;
        ep = ref_prod(a, b, sm);
        et = ref_taint(at, bt, sm, smt);
        multiplier = a; multiplicand = b;
        multiplier_t = at; multiplicand_t = bt;
        signed_mode = sm; signed_mode_t = smt;
        start = 1'b1; start_t = st;
        @(posedge clk); #1;
        start = 1'b0; start_t = 1'b0;
        ctl_exp = st;
        check("busy_after_start", 16'(busy), 16'd1);
        check("busy_t_run", 16'(busy_t), 16'(ctl_exp));
        for (int i = 1; i <= N; i++) begin
            if (poke && i == 2) begin
                start = 1'b1; multiplier = ~a; multiplicand = ~b;
                signed_mode = ~sm; product_ack = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0; product_ack = 1'b0;
            if (i < N) begin
                check("busy_run", 16'(busy), 16'd1);
                check("done_early", 16'(productDone), 16'd0);
                check("prod_hold", product, prev_p);
                check("prodt_hold", product_t, prev_t);
            end else begin
                check("done_at_N", 16'(productDone), 16'd1);
                check("busy_at_N", 16'(busy), 16'd0);
            end
        end
        check("product", product, ep);
        check("product_t", product_t, et);
        check("done_t", 16'(productDone_t), 16'(ctl_exp));
        @(posedge clk); #1;
        check("done_stays", 16'(productDone), 16'd1);
        product_ack = 1'b1; product_ack_t = ackt;
        @(posedge clk); #1;
        product_ack = 1'b0; product_ack_t = 1'b0;
        ctl_exp = ctl_exp | ackt;
        check("done_after_ack", 16'(productDone), 16'd0);
        check("busy_t_idle", 16'(busy_t), 16'(ctl_exp));
        check("done_t_idle", 16'(productDone_t), 16'(ctl_exp));
        check("prod_idle", product, ep);
        prev_p = ep;
        prev_t = et;
    endtask

    initial begin
        rst = 1'b0;
        start = 0; start_t = 0; signed_mode = 0; signed_mode_t = 0;
        multiplier = 0; multiplier_t = 0; multiplicand = 0; multiplicand_t = 0;
        product_ack = 0; product_ack_t = 0;
        prev_p = 0; prev_t = 0; ctl_exp = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_done", 16'(productDone), 16'd0);
        check("rst_prod", product, 16'h0000);
        check("rst_prodt", product_t, 16'h0000);
        check("rst_busy_t", 16'(busy_t), 16'd0);
        check("rst_done_t", 16'(productDone_t), 16'd0);
        @(negedge clk);
        rst = 1'b1;

        run_op(8'd13, 8'd11, 0, 0, 0, 8'h00, 8'h00, 0, 0);
        check("13x11", product, 16'h008F);
        run_op(8'hFD, 8'h05, 1, 0, 0, 8'h00, 8'h00, 0, 0);
        check("FDx05_s", product, 16'hFFF1);
        run_op(8'hFD, 8'h05, 0, 0, 0, 8'h00, 8'h00, 0, 0);
        check("FDx05_u", product, 16'h04F1);
        run_op(8'hFF, 8'hFF, 0, 0, 0, 8'h00, 8'h00, 0, 0);
        check("FFxFF_u", product, 16'hFE01);
        run_op(8'hFF, 8'hFF, 1, 0, 0, 8'h00, 8'h00, 0, 0);
        check("FFxFF_s", product, 16'h0001);
        run_op(8'h37, 8'h5A, 0, 0, 0, 8'h10, 8'h00, 0, 0);
        check("taint_u", product_t, 16'hFFF0);
        run_op(8'h37, 8'h5A, 1, 0, 0, 8'h10, 8'h00, 0, 0);
        check("taint_s", product_t, 16'hFFFF);
        run_op(8'h03, 8'h04, 0, 1, 0, 8'h00, 8'h00, 0, 0);
        check("taint_smt", product_t, 16'hFFFF);
        run_op(8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0);

        // start and ack pulsed mid-run must be ignored
        run_op(8'h9C, 8'h27, 1, 0, 0, 8'h00, 8'h00, 1, 0);

        // reset asserted during RUN cycle 2 aborts the operation
        multiplier = 8'h21; multiplicand = 8'h43; signed_mode = 0;
        multiplier_t = 0; multiplicand_t = 0; signed_mode_t = 0;
        start = 1'b1; start_t = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; start_t = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("mid_busy", 16'(busy), 16'd0);
        check("mid_done", 16'(productDone), 16'd0);
        check("mid_prod", product, 16'h0000);
        check("mid_prodt", product_t, 16'h0000);
        check("mid_busy_t", 16'(busy_t), 16'd0);
        check("mid_done_t", 16'(productDone_t), 16'd0);
        prev_p = 0; prev_t = 0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_done", 16'(productDone), 16'd0);
        @(negedge clk);
        rst = 1'b1;
        run_op(8'h21, 8'h43, 0, 0, 0, 8'h00, 8'h00, 0, 0);
        check("after_reset", product, 16'h08A3);

        // control taint persists through ack and IDLE until an untainted start
        run_op(8'h05, 8'h06, 0, 0, 1, 8'h00, 8'h00, 0, 0);
        @(posedge clk); #1;
        check("ctl_t_idle_hold", 16'(busy_t), 16'd1);
        run_op(8'h07, 8'h08, 0, 0, 0, 8'h00, 8'h00, 0, 1);
        check("ack_t_or", 16'(productDone_t), 16'd1);
        run_op(8'h07, 8'h08, 0, 0, 0, 8'h00, 8'h00, 0, 0);
        check("ctl_t_cleared", 16'(busy_t), 16'd0);

        for (int r = 0; r < 20; r++) begin
            run_op(8'($urandom), 8'($urandom), 1'($urandom),
                   1'($urandom_range(0, 5) == 0), 1'($urandom),
                   ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00,
                   ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00,
                   1'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
